// File: rtl/systolic_skew_feeder.sv
// Buffers one N-beat job and replays it diagonally skewed onto the west/north edges of an NxN systolic array.
// Optional SKEW_FEEDER_ABORT_EN adds an abort input that returns the feeder to its reset state.
module systolic_skew_feeder #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic               clock,
    input  logic               nreset,
`ifdef SKEW_FEEDER_ABORT_EN
    input  logic               abort,
`endif
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [N*WIDTH-1:0] s_a,
    input  logic [N*WIDTH-1:0] s_b,
    output logic [N*WIDTH-1:0] a_out,
    output logic [N*WIDTH-1:0] b_out,
    output logic               ena,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ack
);

    localparam int KW = $clog2(N);
    localparam int TW = $clog2(3*N-2);
    localparam logic [KW-1:0] KLAST = KW'(N-1);
    localparam logic [TW-1:0] TLAST = TW'(3*N-3);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, HOLD} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k;
    logic [TW-1:0]   t;
    logic [WIDTH-1:0] a_buf [N][N];   // [row i][beat k]
    logic [WIDTH-1:0] b_buf [N][N];   // [beat k][column j]
    logic            xfer;
    logic            clr;

`ifdef SKEW_FEEDER_ABORT_EN
    assign clr = abort;
`else
    assign clr = 1'b0;
`endif

    assign s_ready   = (state == IDLE) || (state == LOAD);
    assign ena       = (state == STREAM) || (state == HOLD);
    assign busy      = (state != IDLE);
    assign res_valid = (state == HOLD);
    assign xfer      = s_valid && s_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (xfer) state_nxt = LOAD;
            LOAD:    if (xfer && (k == KLAST)) state_nxt = STREAM;
            STREAM:  if (t == TLAST) state_nxt = HOLD;
            HOLD:    if (res_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // Element A[i][kk] enters row i and B[kk][j] enters column j at stream cycle kk+lane.
    always_comb begin
        a_out = '0;
        b_out = '0;
        if (state == STREAM) begin
            for (int i = 0; i < N; i++) begin
                for (int kk = 0; kk < N; kk++) begin
                    if (int'(t) == i + kk) begin
                        a_out[i*WIDTH +: WIDTH] = a_buf[i][kk];
                        b_out[i*WIDTH +: WIDTH] = b_buf[kk][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            k     <= '0;
            t     <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf[i][j] <= '0;
                    b_buf[i][j] <= '0;
                end
            end
        end else begin
            state <= state_nxt;
            if (clr) begin
                k <= '0;
                t <= '0;
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        a_buf[i][j] <= '0;
                        b_buf[i][j] <= '0;
                    end
                end
            end else begin
                if (xfer) begin
                    for (int i = 0; i < N; i++) begin
                        a_buf[i][k] <= s_a[i*WIDTH +: WIDTH];
                        b_buf[k][i] <= s_b[i*WIDTH +: WIDTH];
                    end
                    k <= (k == KLAST) ? '0 : k + 1'b1;
                end
                if (state == STREAM) begin
                    t <= (t == TLAST) ? '0 : t + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: N=2 and N=4 instances feeding a behavioural accumulator-array model.
module tb_systolic_skew_feeder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        nreset;
    logic        s_valid, s_ready, ena, busy, res_valid, res_ack;
    logic [31:0] s_a, s_b, a_out, b_out;
    logic        s_valid4, s_ready4, ena4, busy4, res_valid4, res_ack4;
    logic [63:0] s_a4, s_b4, a_out4, b_out4;
`ifdef SKEW_FEEDER_ABORT_EN
    logic        abort, abort4;
`endif

    systolic_skew_feeder #(.WIDTH(16), .N(2)) dut2 (
        .clock(clock), .nreset(nreset),
`ifdef SKEW_FEEDER_ABORT_EN
        .abort(abort),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .a_out(a_out), .b_out(b_out), .ena(ena), .busy(busy),
        .res_valid(res_valid), .res_ack(res_ack));

    systolic_skew_feeder #(.WIDTH(16), .N(4)) dut4 (
        .clock(clock), .nreset(nreset),
`ifdef SKEW_FEEDER_ABORT_EN
        .abort(abort4),
`endif
        .s_valid(s_valid4), .s_ready(s_ready4), .s_a(s_a4), .s_b(s_b4),
        .a_out(a_out4), .b_out(b_out4), .ena(ena4), .busy(busy4),
        .res_valid(res_valid4), .res_ack(res_ack4));

    // Array model: cell (i,j) sees row i's west input j cycles late and column j's north input i cycles late.
    logic [15:0] z2 [2][2];
    logic [15:0] ah2 [1][2];
    logic [15:0] bh2 [1][2];
    logic [15:0] z4 [4][4];
    logic [15:0] ah4 [3][4];
    logic [15:0] bh4 [3][4];

    function automatic logic [15:0] adel2(int i, int j);
        if (j == 0) return a_out[i*16 +: 16];
        return ah2[j-1][i];
    endfunction
    function automatic logic [15:0] bdel2(int i, int j);
        if (i == 0) return b_out[j*16 +: 16];
        return bh2[i-1][j];
    endfunction
    function automatic logic [15:0] adel4(int i, int j);
        if (j == 0) return a_out4[i*16 +: 16];
        return ah4[j-1][i];
    endfunction
    function automatic logic [15:0] bdel4(int i, int j);
        if (i == 0) return b_out4[j*16 +: 16];
        return bh4[i-1][j];
    endfunction

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) z2[i][j] <= '0;
                ah2[0][i] <= '0;
                bh2[0][i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    z2[i][j] <= ena ? 16'(z2[i][j] + adel2(i, j) * bdel2(i, j)) : 16'd0;
            for (int i = 0; i < 2; i++) begin
                ah2[0][i] <= a_out[i*16 +: 16];
                bh2[0][i] <= b_out[i*16 +: 16];
            end
        end
    end

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) z4[i][j] <= '0;
                for (int d = 0; d < 3; d++) begin
                    ah4[d][i] <= '0;
                    bh4[d][i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    z4[i][j] <= ena4 ? 16'(z4[i][j] + adel4(i, j) * bdel4(i, j)) : 16'd0;
            for (int i = 0; i < 4; i++) begin
                ah4[0][i] <= a_out4[i*16 +: 16];
                bh4[0][i] <= b_out4[i*16 +: 16];
                for (int d = 1; d < 3; d++) begin
                    ah4[d][i] <= ah4[d-1][i];
                    bh4[d][i] <= bh4[d-1][i];
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    logic [15:0] Am [2][2];
    logic [15:0] Bm [2][2];
    logic [15:0] Cm [2][2];

    function automatic logic [31:0] exp_a(int t);
        logic [31:0] r = '0;
        for (int i = 0; i < 2; i++)
            if (t - i >= 0 && t - i < 2) r[i*16 +: 16] = Am[i][t-i];
        return r;
    endfunction
    function automatic logic [31:0] exp_b(int t);
        logic [31:0] r = '0;
        for (int j = 0; j < 2; j++)
            if (t - j >= 0 && t - j < 2) r[j*16 +: 16] = Bm[t-j][j];
        return r;
    endfunction

    task automatic matmul();
        logic [15:0] s;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = '0;
                for (int k = 0; k < 2; k++) s = 16'(s + Am[i][k] * Bm[k][j]);
                Cm[i][j] = s;
            end
    endtask

    // Presents both beats with up to maxgap idle cycles before each; ends in the first STREAM cycle.
    task automatic load_job(input int maxgap);
        int g;
        for (int k = 0; k < 2; k++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                s_valid = 1'b0;
                s_a = $urandom;
                s_b = $urandom;
                @(negedge clock);
                chk("gap_s_ready", s_ready, 1);
                chk("gap_ena", ena, 0);
                chk("gap_busy", busy, (k > 0));
            end
            chk("beat_s_ready", s_ready, 1);
            chk("beat_ena", ena, 0);
            s_valid = 1'b1;
            s_a = {Am[1][k], Am[0][k]};
            s_b = {Bm[k][1], Bm[k][0]};
            @(negedge clock);
            s_valid = 1'b0;
        end
    endtask

    task automatic stream_job(input logic noise);
        for (int t = 0; t < 4; t++) begin
            chk("stream_a_out", a_out, exp_a(t));
            chk("stream_b_out", b_out, exp_b(t));
            chk("stream_ena", ena, 1);
            chk("stream_s_ready", s_ready, 0);
            chk("stream_res_valid", res_valid, 0);
            if (noise) begin
                s_valid = 1'b1;
                s_a = $urandom;
                s_b = $urandom;
                res_ack = 1'b1;
            end
            @(negedge clock);
        end
        s_valid = 1'b0;
        res_ack = 1'b0;
        chk("hold_res_valid", res_valid, 1);
        chk("hold_ena", ena, 1);
        chk("hold_a_out", a_out, 0);
        chk("hold_b_out", b_out, 0);
        chk("hold_s_ready", s_ready, 0);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) chk("result_z", z2[i][j], Cm[i][j]);
        @(negedge clock);
        chk("hold_stays", res_valid, 1);
        chk("hold_z_kept", z2[1][1], Cm[1][1]);
        res_ack = 1'b1;
        @(negedge clock);
        res_ack = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_ena", ena, 0);
        chk("idle_res_valid", res_valid, 0);
        chk("idle_s_ready", s_ready, 1);
    endtask

    typedef struct packed {
        logic [3:0][15:0] a;   // row-major, element [i*2+j]
        logic [3:0][15:0] b;
        logic [3:0][15:0] c;
        logic [1:0]       gaps;
        logic             noise;
    } vec_t;
    vec_t tbl [4];

    task automatic set_job(input int v);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                Am[i][j] = tbl[v].a[i*2+j];
                Bm[i][j] = tbl[v].b[i*2+j];
                Cm[i][j] = tbl[v].c[i*2+j];
            end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [63:0] e4;
        tbl[0].a = {16'd4, 16'd3, 16'd2, 16'd1};
        tbl[0].b = {16'd8, 16'd7, 16'd6, 16'd5};
        tbl[0].c = {16'd50, 16'd43, 16'd22, 16'd19};
        tbl[0].gaps = 2'd0; tbl[0].noise = 1'b0;
        tbl[1].a = {16'd1, 16'd0, 16'd0, 16'd1};
        tbl[1].b = {16'd1, 16'd0, 16'd0, 16'd1};
        tbl[1].c = {16'd1, 16'd0, 16'd0, 16'd1};
        tbl[1].gaps = 2'd0; tbl[1].noise = 1'b0;
        tbl[2].a = {16'd1, 16'd0, 16'hFFFF, 16'hFFFF};
        tbl[2].b = {16'h8000, 16'd1, 16'd2, 16'hFFFF};
        tbl[2].c = {16'h8000, 16'd1, 16'h7FFE, 16'h0000};
        tbl[2].gaps = 2'd2; tbl[2].noise = 1'b1;
        tbl[3].a = {16'd3, 16'd0, 16'd0, 16'd2};
        tbl[3].b = {16'd7, 16'd6, 16'd5, 16'd4};
        tbl[3].c = {16'd21, 16'd18, 16'd10, 16'd8};
        tbl[3].gaps = 2'd1; tbl[3].noise = 1'b0;

        nreset = 1'b0;
        s_valid = 1'b0; res_ack = 1'b0; s_a = '0; s_b = '0;
        s_valid4 = 1'b0; res_ack4 = 1'b0; s_a4 = '0; s_b4 = '0;
`ifdef SKEW_FEEDER_ABORT_EN
        abort = 1'b0; abort4 = 1'b0;
`endif
        repeat (2) @(negedge clock);
        chk("reset_s_ready", s_ready, 1);
        chk("reset_ena", ena, 0);
        chk("reset_busy", busy, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_a_out", a_out, 0);
        nreset = 1'b1;
        @(negedge clock);

        // Asynchronous reset in the middle of STREAM.
        set_job(0);
        load_job(0);
        @(negedge clock);
        #2 nreset = 1'b0;
        #1;
        chk("midreset_ena", ena, 0);
        chk("midreset_a_out", a_out, 0);
        chk("midreset_b_out", b_out, 0);
        chk("midreset_s_ready", s_ready, 1);
        chk("midreset_busy", busy, 0);
        @(negedge clock);
        nreset = 1'b1;
        @(negedge clock);

        // Table jobs; entries 0 and 1 run back-to-back.
        for (int v = 0; v < 4; v++) begin
            set_job(v);
            load_job(int'(tbl[v].gaps));
            stream_job(tbl[v].noise);
        end

        // Random jobs checked against the plain matrix product.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    Am[i][j] = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
                    Bm[i][j] = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
                end
            matmul();
            load_job(r % 3);
            stream_job(r[0]);
        end

`ifdef SKEW_FEEDER_ABORT_EN
        set_job(3);
        load_job(0);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_ena", ena, 0);
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 1);
        chk("abort_a_out", a_out, 0);
        chk("abort_res_valid", res_valid, 0);
        s_valid = 1'b1; s_a = 32'h0003_0001; s_b = 32'h0006_0005;
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0; s_valid = 1'b0;
        chk("abort_load_busy", busy, 0);
        set_job(0);
        load_job(0);
        stream_job(1'b0);
`endif

        // N=4, every element 0xFFFF.
        s_valid4 = 1'b1; s_a4 = '1; s_b4 = '1;
        repeat (4) @(negedge clock);
        s_valid4 = 1'b0;
        cnt = 0;
        while (ena4 && !res_valid4 && cnt < 50) begin
            e4 = '0;
            for (int i = 0; i < 4; i++)
                if (cnt - i >= 0 && cnt - i < 4) e4[i*16 +: 16] = 16'hFFFF;
            chk("n4_a_out", a_out4, e4);
            chk("n4_b_out", b_out4, e4);
            cnt++;
            @(negedge clock);
        end
        chk("n4_stream_len", cnt, 10);
        chk("n4_res_valid", res_valid4, 1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) chk("n4_z", z4[i][j], 16'h0004);
        res_ack4 = 1'b1;
        @(negedge clock);
        res_ack4 = 1'b0;
        chk("n4_idle_busy", busy4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
